// File: rtl/ladybird_uart_loader_pkg.sv
// Shared types and command bytes for the UART boot loader and its receiver.
package ladybird_config;

  typedef enum logic [2:0] {
    IDLE,
    W_ADDR,
    W_DATA,
    REQ,
    G_ADDR,
    DONE
  } loader_state_t;

  typedef enum logic [1:0] {
    R_IDLE,
    R_START,
    R_DATA,
    R_STOP
  } rx_state_t;

  localparam logic [7:0] CMD_WRITE = 8'h57;
  localparam logic [7:0] CMD_GO    = 8'h47;

endpackage

// File: rtl/ladybird_uart_rx.sv
// 8N1 UART receiver: 2-flop synchroniser, mid-bit sampling, one-cycle valid/frame_err pulses.
module ladybird_uart_rx
  import ladybird_config::*;
#(
  parameter logic [15:0] WTIME = 16'h364
) (
  input  logic       clk_i,
  input  logic       anrst_i,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err
);

  localparam logic [15:0] HALF_M1 = (WTIME >> 1) - 16'd1;
  localparam logic [15:0] FULL_M1 = WTIME - 16'd1;

  logic        rx_meta_reg, rx_sync_reg, rx_prev_reg;
  rx_state_t   state_reg, state_next;
  logic [15:0] cnt_reg, cnt_next;
  logic [2:0]  bit_reg, bit_next;
  logic [7:0]  shift_reg, shift_next;

  // Line idles high, so the synchroniser resets to 1 to avoid a false start edge.
  always_ff @(posedge clk_i or negedge anrst_i) begin
    if (!anrst_i) begin
      rx_meta_reg <= 1'b1;
      rx_sync_reg <= 1'b1;
      rx_prev_reg <= 1'b1;
      state_reg   <= R_IDLE;
      cnt_reg     <= '0;
      bit_reg     <= '0;
      shift_reg   <= '0;
    end else begin
      rx_meta_reg <= rx;
      rx_sync_reg <= rx_meta_reg;
      rx_prev_reg <= rx_sync_reg;
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      bit_reg     <= bit_next;
      shift_reg   <= shift_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg + 16'd1;
    bit_next   = bit_reg;
    shift_next = shift_reg;
    valid      = 1'b0;
    frame_err  = 1'b0;
    case (state_reg)
      R_IDLE: begin
        cnt_next = '0;
        bit_next = '0;
        if (rx_prev_reg && !rx_sync_reg) state_next = R_START;
      end
      R_START: begin
        if (cnt_reg == HALF_M1) begin
          cnt_next   = '0;
          state_next = rx_sync_reg ? R_IDLE : R_DATA;
        end
      end
      R_DATA: begin
        if (cnt_reg == FULL_M1) begin
          cnt_next   = '0;
          shift_next = {rx_sync_reg, shift_reg[7:1]};
          bit_next   = bit_reg + 3'd1;
          if (bit_reg == 3'd7) state_next = R_STOP;
        end
      end
      R_STOP: begin
        if (cnt_reg == FULL_M1) begin
          cnt_next   = '0;
          state_next = R_IDLE;
          valid      = rx_sync_reg;
          frame_err  = !rx_sync_reg;
        end
      end
      default: state_next = R_IDLE;
    endcase
  end

  assign data = shift_reg;

endmodule

// File: rtl/ladybird_uart_loader.sv
// UART boot loader: parses W/G commands from the host and drives word writes and the boot release.
module ladybird_uart_loader
  import ladybird_config::*;
#(
  parameter logic [15:0] WTIME   = 16'h364,
  parameter logic [23:0] TIMEOUT = 24'd10_000_000,
  parameter int          XLEN    = 32
) (
  input  logic            clk_i,
  input  logic            anrst_i,
  input  logic            uart_rx,
  output logic            bus_valid,
  input  logic            bus_ready,
  output logic [XLEN-1:0] bus_addr,
  output logic [XLEN-1:0] bus_wdata,
  output logic [3:0]      bus_wstrb,
  output logic            boot_start,
  output logic [XLEN-1:0] boot_pc,
  output logic            busy,
  output logic            err_frame,
  output logic            err_overrun
);

  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_frame_err;

  ladybird_uart_rx #(
    .WTIME (WTIME)
  ) u_rx (
    .clk_i     (clk_i),
    .anrst_i   (anrst_i),
    .rx        (uart_rx),
    .data      (rx_data),
    .valid     (rx_valid),
    .frame_err (rx_frame_err)
  );

  logic [7:0]      hold_data_reg;
  logic            hold_full_reg;
  logic            err_frame_reg, err_overrun_reg;
  loader_state_t   state_reg, state_next;
  logic [XLEN-1:0] addr_reg, addr_next;
  logic [XLEN-1:0] data_reg, data_next;
  logic [1:0]      cnt_reg, cnt_next;
  logic [23:0]     tmo_reg, tmo_next;
  logic            consume;
  logic            collecting;

  // A consume frees the slot in the same cycle, so a simultaneous delivery refills it.
  always_ff @(posedge clk_i or negedge anrst_i) begin
    if (!anrst_i) begin
      hold_data_reg   <= '0;
      hold_full_reg   <= 1'b0;
      err_frame_reg   <= 1'b0;
      err_overrun_reg <= 1'b0;
    end else begin
      if (consume) begin
        hold_full_reg <= rx_valid;
        if (rx_valid) hold_data_reg <= rx_data;
      end else if (rx_valid) begin
        if (hold_full_reg) begin
          err_overrun_reg <= 1'b1;
        end else begin
          hold_full_reg <= 1'b1;
          hold_data_reg <= rx_data;
        end
      end
      if (rx_frame_err) err_frame_reg <= 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge anrst_i) begin
    if (!anrst_i) begin
      state_reg <= IDLE;
      addr_reg  <= '0;
      data_reg  <= '0;
      cnt_reg   <= '0;
      tmo_reg   <= '0;
    end else begin
      state_reg <= state_next;
      addr_reg  <= addr_next;
      data_reg  <= data_next;
      cnt_reg   <= cnt_next;
      tmo_reg   <= tmo_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    addr_next  = addr_reg;
    data_next  = data_reg;
    cnt_next   = cnt_reg;
    consume    = hold_full_reg && (state_reg != REQ);
    collecting = (state_reg == W_ADDR) || (state_reg == W_DATA) || (state_reg == G_ADDR);
    tmo_next   = (!collecting || consume) ? 24'd0 : tmo_reg + 24'd1;

    case (state_reg)
      IDLE: begin
        if (consume) begin
          cnt_next = '0;
          if (hold_data_reg == CMD_WRITE)   state_next = W_ADDR;
          else if (hold_data_reg == CMD_GO) state_next = G_ADDR;
        end
      end
      W_ADDR, G_ADDR: begin
        if (consume) begin
          // Little-endian: each new byte enters at the top and the field shifts down.
          addr_next = {hold_data_reg, addr_reg[XLEN-1:8]};
          cnt_next  = cnt_reg + 2'd1;
          if (cnt_reg == 2'd3) state_next = (state_reg == W_ADDR) ? W_DATA : DONE;
        end else if (tmo_reg == TIMEOUT) begin
          state_next = IDLE;
        end
      end
      W_DATA: begin
        if (consume) begin
          data_next = {hold_data_reg, data_reg[XLEN-1:8]};
          cnt_next  = cnt_reg + 2'd1;
          if (cnt_reg == 2'd3) state_next = REQ;
        end else if (tmo_reg == TIMEOUT) begin
          state_next = IDLE;
        end
      end
      REQ: begin
        if (bus_ready) state_next = IDLE;
      end
      DONE: state_next = DONE;
      default: state_next = IDLE;
    endcase
  end

  assign bus_valid   = (state_reg == REQ);
  assign bus_addr    = {addr_reg[XLEN-1:2], 2'b00};
  assign bus_wdata   = data_reg;
  assign bus_wstrb   = bus_valid ? 4'hF : 4'h0;
  assign boot_start  = (state_reg == DONE);
  assign boot_pc     = boot_start ? addr_reg : '0;
  assign busy        = (state_reg != IDLE) && (state_reg != DONE);
  assign err_frame   = err_frame_reg;
  assign err_overrun = err_overrun_reg;

endmodule

// File: tb/tb_ladybird_uart_loader.sv
// Directed bench for the UART loader: table of write frames plus hand-written corner sequences.
module tb_ladybird_uart_loader;

  localparam logic [15:0] WTIME   = 16'd16;
  localparam logic [23:0] TIMEOUT = 24'd400;

  logic        clk_i = 1'b0;
  logic        anrst_i = 1'b0;
  logic        uart_rx = 1'b1;
  logic        bus_ready = 1'b1;
  logic        bus_valid;
  logic [31:0] bus_addr, bus_wdata, boot_pc;
  logic [3:0]  bus_wstrb;
  logic        boot_start, busy, err_frame, err_overrun;

  ladybird_uart_loader #(
    .WTIME   (WTIME),
    .TIMEOUT (TIMEOUT),
    .XLEN    (32)
  ) dut (
    .clk_i       (clk_i),
    .anrst_i     (anrst_i),
    .uart_rx     (uart_rx),
    .bus_valid   (bus_valid),
    .bus_ready   (bus_ready),
    .bus_addr    (bus_addr),
    .bus_wdata   (bus_wdata),
    .bus_wstrb   (bus_wstrb),
    .boot_start  (boot_start),
    .boot_pc     (boot_pc),
    .busy        (busy),
    .err_frame   (err_frame),
    .err_overrun (err_overrun)
  );

  always #5 clk_i = ~clk_i;

  int n_vec = 0;
  int n_err = 0;

  // Handshake monitor: one line per bus transaction.
  int          hs_count = 0;
  logic [31:0] last_addr = '0, last_data = '0;
  logic [3:0]  last_strb = '0;
  always @(negedge clk_i) begin
    if (anrst_i && bus_valid && bus_ready) begin
      hs_count  = hs_count + 1;
      last_addr = bus_addr;
      last_data = bus_wdata;
      last_strb = bus_wstrb;
      $display("txn %0d: addr=%h wdata=%h wstrb=%h", hs_count, bus_addr, bus_wdata, bus_wstrb);
    end
  end

  // Stability watcher for the backpressure window.
  logic        watch = 1'b0;
  int          watch_cycles = 0;
  logic        stable_bad = 1'b0;
  logic [31:0] cap_addr = '0, cap_data = '0;
  always @(negedge clk_i) begin
    if (watch) begin
      watch_cycles = watch_cycles + 1;
      if (bus_valid !== 1'b1 || bus_addr !== cap_addr || bus_wdata !== cap_data || bus_wstrb !== 4'hF)
        stable_bad = 1'b1;
    end else begin
      watch_cycles = 0;
      stable_bad   = 1'b0;
    end
  end

  typedef struct {
    logic        use_junk;
    logic [7:0]  junk;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] exp_addr;
    logic [31:0] exp_data;
  } vec_t;
  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk_i);
    #2;
  endtask

  task automatic drive_bit(input logic v);
    uart_rx = v;
    repeat (WTIME) @(posedge clk_i);
    #2;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    @(posedge clk_i);
    #2;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop);
    uart_rx = 1'b1;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], 1'b1);
  endtask

  task automatic send_write(input logic [31:0] a, input logic [31:0] d);
    send_byte(8'h57, 1'b1);
    send_word(a);
    send_word(d);
  endtask

  task automatic wait_hs(input string name, input int target, input int budget);
    int c;
    c = 0;
    while (hs_count < target && c < budget) begin
      @(negedge clk_i);
      c++;
    end
    check(name, hs_count, target);
  endtask

  task automatic wait_valid(input string name, input int budget);
    int c;
    c = 0;
    while (bus_valid !== 1'b1 && c < budget) begin
      @(negedge clk_i);
      c++;
    end
    check(name, bus_valid, 1'b1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, vectors=%0d", n_vec);
    $fatal(1, "watchdog");
  end

  initial begin
    int base;

    vecs[0] = '{1'b0, 8'h00, 32'h9000_0000, 32'hDEAD_BEEF, 32'h9000_0000, 32'hDEAD_BEEF};
    vecs[1] = '{1'b1, 8'h41, 32'h9000_0007, 32'h1234_5678, 32'h9000_0004, 32'h1234_5678};
    vecs[2] = '{1'b0, 8'h00, 32'hFFFF_FFFC, 32'h0000_0000, 32'hFFFF_FFFC, 32'h0000_0000};
    vecs[3] = '{1'b1, 8'h00, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'hFFFF_FFFF};
    vecs[4] = '{1'b0, 8'h00, 32'h4757_5747, 32'h5757_4747, 32'h4757_5744, 32'h5757_4747};

    // Reset state
    step(3);
    @(negedge clk_i);
    check("rst_valid", bus_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_boot", boot_start, 1'b0);
    check("rst_pc", boot_pc, 32'h0);
    check("rst_errs", {err_frame, err_overrun}, 2'b00);
    check("rst_strb", bus_wstrb, 4'h0);
    step(1);
    anrst_i = 1'b1;
    step(5);

    // Table-driven write frames
    for (int i = 0; i < 5; i++) begin
      base = hs_count;
      if (vecs[i].use_junk) send_byte(vecs[i].junk, 1'b1);
      send_write(vecs[i].addr, vecs[i].data);
      wait_hs("tbl_hs", base + 1, 200);
      check("tbl_addr", last_addr, vecs[i].exp_addr);
      check("tbl_data", last_data, vecs[i].exp_data);
      check("tbl_strb", last_strb, 4'hF);
      step(5);
      @(negedge clk_i);
      check("tbl_busy", busy, 1'b0);
    end

    // Backpressure with a following 'W' held in the holding register
    step(1);
    bus_ready = 1'b0;
    base = hs_count;
    send_write(32'h9000_0000, 32'hDEAD_BEEF);
    wait_valid("bp_valid", 100);
    cap_addr = 32'h9000_0000;
    cap_data = 32'hDEAD_BEEF;
    watch = 1'b1;
    send_byte(8'h57, 1'b1);
    step(20);
    @(negedge clk_i);
    #1;
    check("bp_cycles", 32'(watch_cycles >= 50), 32'd1);
    check("bp_stable", stable_bad, 1'b0);
    check("bp_no_hs", hs_count, base);
    watch = 1'b0;
    step(1);
    bus_ready = 1'b1;
    wait_hs("bp_hs", base + 1, 50);
    check("bp_addr", last_addr, 32'h9000_0000);
    step(5);
    @(negedge clk_i);
    check("bp_held_w", busy, 1'b1);
    check("bp_valid_low", bus_valid, 1'b0);
    send_word(32'h9000_0010);
    send_word(32'h0000_00A5);
    wait_hs("bp_hs2", base + 2, 200);
    check("bp_addr2", last_addr, 32'h9000_0010);
    check("bp_data2", last_data, 32'h0000_00A5);

    // Framing error on a 'W' byte
    send_byte(8'h57, 1'b0);
    step(WTIME);
    @(negedge clk_i);
    check("fe_flag", err_frame, 1'b1);
    check("fe_idle", busy, 1'b0);
    check("fe_no_ovr", err_overrun, 1'b0);
    base = hs_count;
    send_write(32'h9000_0008, 32'hCAFE_F00D);
    wait_hs("fe_hs", base + 1, 200);
    check("fe_addr", last_addr, 32'h9000_0008);
    check("fe_data", last_data, 32'hCAFE_F00D);

    // Timeout mid-address
    send_byte(8'h57, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
    @(negedge clk_i);
    check("to_busy", busy, 1'b1);
    step(int'(TIMEOUT) + 10);
    @(negedge clk_i);
    check("to_abort", busy, 1'b0);
    base = hs_count;
    send_write(32'h9000_0004, 32'h0BAD_F00D);
    wait_hs("to_hs", base + 1, 200);
    check("to_addr", last_addr, 32'h9000_0004);
    check("to_data", last_data, 32'h0BAD_F00D);
    step(50);
    check("to_one_hs", hs_count, base + 1);

    // Overrun while parked in REQ
    bus_ready = 1'b0;
    base = hs_count;
    send_write(32'h9000_000C, 32'h1111_2222);
    wait_valid("ov_valid", 100);
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
    @(negedge clk_i);
    check("ov_flag", err_overrun, 1'b1);
    check("ov_no_hs", hs_count, base);
    step(1);
    bus_ready = 1'b1;
    wait_hs("ov_hs", base + 1, 50);
    check("ov_data", last_data, 32'h1111_2222);
    step(20);
    @(negedge clk_i);
    check("ov_idle", busy, 1'b0);

    // GO, then a write that must be ignored
    send_byte(8'h47, 1'b1);
    send_word(32'h9000_0000);
    step(3);
    @(negedge clk_i);
    check("go_start", boot_start, 1'b1);
    check("go_pc", boot_pc, 32'h9000_0000);
    check("go_busy", busy, 1'b0);
    base = hs_count;
    send_write(32'h9000_0020, 32'h5555_AAAA);
    step(50);
    @(negedge clk_i);
    check("go_no_hs", hs_count, base);
    check("go_held", boot_start, 1'b1);
    check("go_no_valid", bus_valid, 1'b0);

    // Asynchronous reset while parked in REQ
    step(1);
    anrst_i = 1'b0;
    step(2);
    anrst_i = 1'b1;
    step(2);
    @(negedge clk_i);
    check("rr_boot_clr", boot_start, 1'b0);
    bus_ready = 1'b0;
    send_byte(8'h57, 1'b0);
    step(WTIME);
    base = hs_count;
    send_write(32'h9000_0030, 32'h7777_8888);
    wait_valid("rr_valid", 100);
    check("rr_busy_pre", busy, 1'b1);
    check("rr_fe_pre", err_frame, 1'b1);
    @(posedge clk_i);
    #3;
    anrst_i = 1'b0;
    #1;
    check("rr_valid_async", bus_valid, 1'b0);
    check("rr_busy_async", busy, 1'b0);
    check("rr_boot_async", boot_start, 1'b0);
    check("rr_errs_async", {err_frame, err_overrun}, 2'b00);
    step(2);
    anrst_i = 1'b1;
    bus_ready = 1'b1;
    step(30);
    @(negedge clk_i);
    check("rr_no_hs", hs_count, base);
    check("rr_idle", busy, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ladybird_uart_loader.md
Name: ladybird_uart_loader

Overview:
UART-driven boot loader and bus initiator. Deserialises host bytes from the UART RX pin, parses a small command stream and issues 32-bit word writes on the data-bus request channel to load a program into RAM. On a GO command it releases the core by driving boot_start and boot_pc. It is the initiator counterpart to ladybird_serial_interface, which is a bus responder.

Parameters:
WTIME, 16'h364, clk_i cycles per UART bit (100 MHz / 115200 baud).
TIMEOUT, 24'd10_000_000, idle clk_i cycles mid-command before the parser aborts to IDLE.
XLEN, 32, address and data width.

Ports:
clk_i  input  1  system clock
anrst_i  input  1  reset; asynchronous assert, active-low
uart_rx  input  1  asynchronous serial in; idle high
bus_valid  output  1  write request valid
bus_ready  input  1  responder accepts the request in the cycle where bus_valid && bus_ready
bus_addr  output  XLEN  word address, bits [1:0] always 0
bus_wdata  output  XLEN  write data
bus_wstrb  output  4  byte strobes, always 4'hF when bus_valid
boot_start  output  1  level, high once GO completes; held until reset
boot_pc  output  XLEN  start PC latched by GO
busy  output  1  parser not in IDLE
err_frame  output  1  sticky, set when a received stop bit is 0
err_overrun  output  1  sticky, set when a byte arrives while the holding register is full

Behaviour:
- Reset (anrst_i low): all outputs 0; FSM in IDLE; RX in R_IDLE; holding register empty.
- RX synchroniser: 2 flops on uart_rx. All logic uses the synchronised signal.
- RX FSM:
  - R_IDLE: wait for a falling edge on the synchronised input, then go to R_START.
  - R_START: count WTIME/2. If the line is still 0, go to R_DATA; otherwise return to R_IDLE (glitch).
  - R_DATA: sample every WTIME cycles, 8 bits, LSB first.
  - R_STOP: sample after WTIME. If the stop bit is 1, deliver the byte to the holding register. If it is 0, discard the byte and set err_frame.
- Holding register: 1 byte plus a full flag.
  - Delivery while full: keep the old byte, drop the new one, set err_overrun.
  - The parser consumes the byte in one cycle whenever it is in a byte-accepting state.
- Parser FSM; multi-byte fields are little-endian:
  - IDLE: 0x57 'W' → W_ADDR with count 0. 0x47 'G' → G_ADDR. Any other byte is consumed and ignored.
  - W_ADDR: collect 4 bytes into addr; then W_DATA.
  - W_DATA: collect 4 bytes into data; then REQ.
  - REQ: bus_valid=1, bus_addr={addr[31:2],2'b00}, bus_wdata=data, bus_wstrb=4'hF.
    - Outputs stay stable until bus_ready.
    - On the handshake cycle, bus_valid goes low next cycle and the FSM returns to IDLE.
    - No bytes are consumed in REQ. An RX byte arriving meanwhile waits in the holding register.
  - G_ADDR: collect 4 bytes; then DONE.
  - DONE: boot_pc=collected addr, boot_start=1 from the next cycle onward. All further bytes are consumed and ignored. Only reset leaves DONE.
- Timeout: in W_ADDR, W_DATA or G_ADDR, a counter clears on each consumed byte. When it reaches TIMEOUT, the FSM returns to IDLE and partial fields are discarded. REQ is never aborted.
- Minimum latency: the last data byte's stop-bit sample is followed by bus_valid 2 cycles later (holding-register write, then parser transition).
- Simultaneous events: a byte delivery and a parser consume in the same cycle cannot both apply to one byte. Consume has priority and the new byte refills the register; this is not an overrun.
- busy = (state != IDLE) && (state != DONE).

Decomposition:
- ladybird_config package: loader_state_t enum (IDLE, W_ADDR, W_DATA, REQ, G_ADDR, DONE), rx_state_t enum, CMD_WRITE=8'h57, CMD_GO=8'h47.
- Sub-module ladybird_uart_rx (params WTIME; ports clk_i, anrst_i, rx, data[7:0], valid pulse, frame_err pulse). The loader instantiates it and owns the holding register and parser.

Test Plan:
- Write: send 57 00 00 00 90 EF BE AD DE with bus_ready=1 → one handshake, addr 32'h9000_0000, wdata 32'hDEAD_BEEF, wstrb 4'hF, busy returns to 0.
- Backpressure: same frame, bus_ready low for 50 cycles → bus_valid/addr/wdata stable for all 50 cycles; exactly one handshake. A following 'W' byte is held and parsed after the handshake.
- GO: send 47 00 00 00 90 → boot_pc=32'h9000_0000, boot_start=1 and held; a later 57... frame produces no bus_valid.
- Framing error: byte 0x57 with stop bit 0 → err_frame=1, parser stays in IDLE; a following valid write frame still completes.
- Timeout: send 57 00 00, then silence for TIMEOUT+10 cycles, then a full write frame to 32'h9000_0004 → only the second write appears on the bus.
- Reset mid-REQ: hold bus_ready=0, pulse anrst_i low → bus_valid, busy, boot_start and both error flags read 0 immediately (asynchronously); parser returns to IDLE.
